// File: rtl/mem_sequencer.sv
// mem_sequencer: fetch/decode/execute control sequencer for the basic
// processor. Drives the RAM strobes (load_MAR, load_MDR, MDR_bus, CS, R_NW)
// and the PC/IR/ACC/ALU strobes on the shared sysbus.
// Outputs are decoded from the state register. They also follow op in S3-S5,
// z_flag in S3, and reset, which forces every output to its default while
// it is high.
// Optional feature: define SEQ_HALT_EN to make opcode 111 a HALT that parks
// the FSM in state SH (halted=1) until reset. Without it, 111 is a NOP.
module mem_sequencer #(
    parameter int OP_W   = 3,
    parameter int WORD_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            load_MDR,
    output logic            MDR_bus,
    output logic            CS,
    output logic            R_NW,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            halted
);

    // The opcode field sits inside a system word, so it can never be wider.
    localparam int OPF_W = (OP_W < WORD_W) ? OP_W : WORD_W;

    localparam logic [OPF_W-1:0] OP_LOAD  = OPF_W'(0);
    localparam logic [OPF_W-1:0] OP_STORE = OPF_W'(1);
    localparam logic [OPF_W-1:0] OP_ADD   = OPF_W'(2);
    localparam logic [OPF_W-1:0] OP_SUB   = OPF_W'(3);
    localparam logic [OPF_W-1:0] OP_BNE   = OPF_W'(4);
    localparam logic [OPF_W-1:0] OP_JMP   = OPF_W'(5);
`ifdef SEQ_HALT_EN
    localparam logic [OPF_W-1:0] OP_HALT  = OPF_W'(7);
`endif

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
`ifdef SEQ_HALT_EN
        , SH = 3'd6
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [OPF_W-1:0] opc;
    logic            mem_op;

    assign opc    = op[OPF_W-1:0];
    // Instructions that need the S4/S5 memory phase.
    assign mem_op = (opc == OP_LOAD) || (opc == OP_STORE) ||
                    (opc == OP_ADD)  || (opc == OP_SUB);

    // Next-state decode; illegal encodings fall back to S0.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = S1;
            S1: state_d = S2;
            S2: state_d = S3;
            S3: begin
                if (mem_op)
                    state_d = S4;
`ifdef SEQ_HALT_EN
                else if (opc == OP_HALT)
                    state_d = SH;
`endif
                else
                    state_d = S0;
            end
            S4: state_d = mem_op ? S5 : S0;
            S5: state_d = S0;
`ifdef SEQ_HALT_EN
            SH: state_d = SH;
`endif
            default: state_d = S0;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= S0;
        else
            state_q <= state_d;
    end

    // Control strobes for the current state; reset forces defaults so a
    // reset landing in S5 of STORE never produces a RAM write.
    always_comb begin
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_IR  = 1'b0;
        Addr_bus = 1'b0;
        load_MAR = 1'b0;
        load_MDR = 1'b0;
        MDR_bus  = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b1;
        ALU_ACC  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            case (state_q)
                S0: begin
                    PC_bus   = 1'b1;
                    load_MAR = 1'b1;
                    INC_PC   = 1'b1;
                end
                S1: CS = 1'b1;
                S2: begin
                    MDR_bus = 1'b1;
                    load_IR = 1'b1;
                end
                S3: begin
                    if (mem_op) begin
                        Addr_bus = 1'b1;
                        load_MAR = 1'b1;
                    end else if ((opc == OP_JMP) || (opc == OP_BNE && !z_flag)) begin
                        Addr_bus = 1'b1;
                        load_PC  = 1'b1;
                    end
`ifdef SEQ_HALT_EN
                    halted = (opc == OP_HALT);
`endif
                end
                S4: begin
                    if (opc == OP_STORE) begin
                        ACC_bus  = 1'b1;
                        load_MDR = 1'b1;
                    end else if (mem_op) begin
                        CS = 1'b1;
                    end
                end
                S5: begin
                    case (opc)
                        OP_LOAD: begin
                            MDR_bus  = 1'b1;
                            ALU_ACC  = 1'b1;
                            load_ACC = 1'b1;
                        end
                        OP_ADD: begin
                            MDR_bus  = 1'b1;
                            ALU_add  = 1'b1;
                            load_ACC = 1'b1;
                        end
                        OP_SUB: begin
                            MDR_bus  = 1'b1;
                            ALU_sub  = 1'b1;
                            load_ACC = 1'b1;
                        end
                        OP_STORE: begin
                            CS   = 1'b1;
                            R_NW = 1'b0;
                        end
                        default: ;
                    endcase
                end
`ifdef SEQ_HALT_EN
                SH: halted = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: table of per-opcode output sequences, replayed
// directly and in random order through a scoreboard queue, plus hand-written
// reset-in-STORE and HALT sequences.
module tb_mem_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic       z_flag;
    logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus;
    logic load_MAR, load_MDR, MDR_bus, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted;

    always #5 clk = ~clk;

    mem_sequencer #(.OP_W(3), .WORD_W(8)) dut (
        .clock(clk), .reset(reset), .op(op), .z_flag(z_flag),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
        .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
        .load_MDR(load_MDR), .MDR_bus(MDR_bus), .CS(CS), .R_NW(R_NW),
        .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .halted(halted)
    );

    localparam logic [15:0] ACCB = 16'h8000, LDACC = 16'h4000, PCB = 16'h2000,
                            LDPC = 16'h1000, INC = 16'h0800, LDIR = 16'h0400,
                            ADDR = 16'h0200, LDMAR = 16'h0100, LDMDR = 16'h0080,
                            MDRB = 16'h0040, CSB = 16'h0020, RNW = 16'h0010,
                            AACC = 16'h0008, AADD = 16'h0004, ASUB = 16'h0002,
                            HLT = 16'h0001;
    localparam logic [15:0] V_RST = RNW;
    localparam logic [15:0] V_S0 = PCB | LDMAR | INC | RNW;
    localparam logic [15:0] V_S1 = CSB | RNW;
    localparam logic [15:0] V_S2 = MDRB | LDIR | RNW;
    localparam logic [15:0] V_S3M = ADDR | LDMAR | RNW;
    localparam logic [15:0] V_BR = ADDR | LDPC | RNW;
    localparam logic [15:0] V_RD = CSB | RNW;

    logic [15:0] outv;
    assign outv = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus,
                   load_MAR, load_MDR, MDR_bus, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted};

    typedef struct {
        logic [2:0]       op;
        logic             z;
        int               n;
        logic [5:0][15:0] exp;
        string            nm;
    } row_t;

`ifdef SEQ_HALT_EN
    localparam int NROWS = 8;
`else
    localparam int NROWS = 9;
`endif
    row_t        tbl [NROWS];
    logic [15:0] exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic row_t mk(input logic [2:0] o, input logic z, input int n, input string nm,
                                input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
        row_t r;
        r.op = o; r.z = z; r.n = n; r.nm = nm;
        r.exp[0] = V_S0; r.exp[1] = V_S1; r.exp[2] = V_S2;
        r.exp[3] = e3; r.exp[4] = e4; r.exp[5] = e5;
        return r;
    endfunction

    // Compare the current outputs against the oldest expected vector.
    task automatic step(input string nm);
        logic [15:0] e;
        @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %h", nm, outv);
        end else begin
            e = exp_q.pop_front();
            if (outv === e) n_pass++;
            else $display("FAIL %s t=%0t: got %h expected %h", nm, $time, outv, e);
        end
    endtask

    // One full instruction; when rnd_z is set, z_flag is randomised in every
    // cycle except the S3 cycle of a BNE.
    task automatic run_row(input int idx, input bit rnd_z);
        for (int c = 0; c < tbl[idx].n; c++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            op = tbl[idx].op;
            if (tbl[idx].op == 3'b100 && c == 3) z_flag = tbl[idx].z;
            else if (rnd_z) z_flag = 1'($urandom);
            else z_flag = tbl[idx].z;
            exp_q.push_back(tbl[idx].exp[c]);
            step(tbl[idx].nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(3'b000, 1'b0, 6, "load",  V_S3M, V_RD, MDRB | AACC | LDACC | RNW);
        tbl[1] = mk(3'b001, 1'b0, 6, "store", V_S3M, ACCB | LDMDR | RNW, CSB);
        tbl[2] = mk(3'b010, 1'b1, 6, "add",   V_S3M, V_RD, MDRB | AADD | LDACC | RNW);
        tbl[3] = mk(3'b011, 1'b0, 6, "sub",   V_S3M, V_RD, MDRB | ASUB | LDACC | RNW);
        tbl[4] = mk(3'b100, 1'b0, 4, "bne_z0", V_BR, 16'h0, 16'h0);
        tbl[5] = mk(3'b100, 1'b1, 4, "bne_z1", RNW, 16'h0, 16'h0);
        tbl[6] = mk(3'b101, 1'b1, 4, "jmp",   V_BR, 16'h0, 16'h0);
        tbl[7] = mk(3'b110, 1'b0, 4, "nop110", RNW, 16'h0, 16'h0);
`ifndef SEQ_HALT_EN
        tbl[8] = mk(3'b111, 1'b0, 4, "nop111", RNW, 16'h0, 16'h0);
`endif

        // Reset held: all defaults.
        reset = 1'b1; op = 3'b110; z_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp_q.push_back(V_RST);
            step("reset_hold");
        end

        // Release with NOP: S0 pattern first, recurring every 4 cycles.
        run_row(7, 1'b0);
        run_row(7, 1'b0);

        // Every table row in order, then a random mix.
        for (int i = 0; i < NROWS; i++) run_row(i, 1'b0);
        for (int k = 0; k < 40; k++) run_row(int'($urandom_range(NROWS - 1, 0)), 1'b1);

        // Reset arriving in S5 of STORE must suppress the RAM write.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            op = 3'b001;
            exp_q.push_back(tbl[1].exp[c]);
            step("store_pre_reset");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(V_RST);
        step("store_s5_reset");
        @(posedge clk); #1;
        exp_q.push_back(V_RST);
        step("post_reset_default");
        @(posedge clk); #1;
        reset = 1'b0; op = 3'b110;
        exp_q.push_back(V_S0);
        step("post_reset_s0");
        @(posedge clk); #1;
        exp_q.push_back(V_S1);
        step("post_reset_s1");
        for (int c = 2; c < 4; c++) begin
            @(posedge clk); #1;
            exp_q.push_back(tbl[7].exp[c]);
            step("post_reset_nop");
        end

`ifdef SEQ_HALT_EN
        // HALT: halted from the S3 cycle on, no strobes until reset.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            op = 3'b111;
            exp_q.push_back(tbl[7].exp[c]);
            step("halt_fetch");
        end
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            op = 3'($urandom);
            z_flag = 1'($urandom);
            if (c == 0) op = 3'b111;
            exp_q.push_back(RNW | HLT);
            step("halted");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(V_RST);
        step("halt_reset");
        @(posedge clk); #1;
        reset = 1'b0; op = 3'b110;
        exp_q.push_back(V_S0);
        step("halt_cleared");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
